alu_muldiv_seq: RTL
===================

Name: alu_muldiv_seq

Overview:
- Next-generation execute-stage ALU for the RV32 core, parametrised in DATA_WIDTH.
- Keeps the existing single-cycle integer ops and adds a multi-cycle M-extension unit: MUL, MULH, MULHU, DIV, DIVU, REM, REMU.
- Registered output with valid/ready handshakes on both sides, so the pipeline can stall on long ops.
- Sits between the register-read stage and writeback, replacing the combinational ALU.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be a power of two, >= 8.
- SHAMT_W, $clog2(DATA_WIDTH), shift-amount bits taken from rs2 (derived, not overridden).
- EN_MULDIV, 1, when 0, ops 0x0B-0x11 return 0 in one cycle and the iterative datapath is not built.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; high only in IDLE
- rs1  in  DATA_WIDTH  operand A
- rs2  in  DATA_WIDTH  operand B
- alu_control  in  5  opcode (encoding below)
- out_valid  out  1  rd/zero valid
- out_ready  in  1  consumer accepts result
- rd  out  DATA_WIDTH  result register
- zero  out  1  rd == 0
- busy  out  1  state != IDLE

Behaviour:
- Opcode encoding:
  - 0x00 ADD, 0x01 SUB, 0x02 SLL, 0x03 SLT, 0x04 SLTU, 0x05 XOR, 0x06 SRL, 0x07 SRA, 0x08 OR, 0x09 AND, 0x0A CLR (rd=0).
  - 0x0B MUL (low half), 0x0C MULH (signed x signed, high half), 0x0D MULHU (unsigned high half), 0x0E DIV, 0x0F DIVU, 0x10 REM, 0x11 REMU.
  - 0x12-0x1F: rd=0, single-cycle.
- Shifts use rs2[SHAMT_W-1:0] only. SLT/SLTU zero-extend the 1-bit result.
- zero = (rd == 0) for every op. This is a deliberate generalisation of the old SUB-only flag.
- Reset (async, rst_n low): state=IDLE; rd=0, zero=0, out_valid=0, busy=0; in_ready=1 once rst_n is high. Reset mid-operation aborts and discards the op; no result is produced.
- FSM states: IDLE, CALC, DONE.
  - IDLE, on in_valid&in_ready: latch opcode and operands.
    - Single-cycle op or special-case divide: compute, load rd/zero -> DONE. out_valid rises on the next edge (latency 1).
    - Iterative op: -> CALC with count=0.
  - CALC: one iteration per cycle, DATA_WIDTH iterations.
    - Multiply: shift-add on absolute values; sign fix-up in the final cycle for MULH.
    - Divide: restoring divide on magnitudes; quotient sign = sign(rs1)^sign(rs2), remainder sign = sign(rs1).
    - At count==DATA_WIDTH-1, load rd/zero -> DONE. Latency from accept to out_valid = DATA_WIDTH+1 cycles (33 at default).
  - DONE: out_valid=1; rd/zero held stable. On out_ready -> IDLE; out_valid drops on that edge.
- No new op is accepted in DONE (in_ready=0). Back-to-back throughput for single-cycle ops is therefore one op per 2 cycles.
- Inputs are sampled only on the accept edge; rs1/rs2/alu_control may change freely while busy.
- Special cases (resolved in IDLE, latency 1):
  - Divide by zero: DIV/DIVU give rd = all-ones; REM/REMU give rd = rs1.
  - Signed overflow (rs1 = most-negative, rs2 = -1): DIV gives most-negative; REM gives 0.
- MUL low half is identical for signed and unsigned operands. All arithmetic wraps modulo 2^DATA_WIDTH; there are no overflow flags.
- in_valid while in_ready=0 is ignored; the requester must hold it until accepted.

Test Plan:
- Reset mid-CALC: start DIVU 100/7, assert rst_n low at cycle 10 -> rd=0, out_valid=0, busy=0, in_ready=1 after release; no stale result appears.
- Single-cycle ops: ADD 0x7FFFFFFF+1 -> rd=0x80000000, zero=0, out_valid 1 cycle after accept. SUB 5-5 -> rd=0, zero=1. SRA 0x80000000 by rs2=0x24 (shamt 4) -> 0xF8000000.
- Multiply: MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE. MULH -1*-1 -> 0. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. out_valid exactly 33 cycles after accept.
- Divide: DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14. REMU 100/7 -> 2, all in 33 cycles.
- Special cases: DIV 5/0 -> 0xFFFFFFFF. REMU 5/0 -> 5. DIV 0x80000000/-1 -> 0x80000000. REM same operands -> 0, zero=1. Each with latency 1.
- Backpressure: hold out_ready=0 for 10 cycles after MUL completes -> rd stable, out_valid=1, in_ready=0, and an in_valid pulse during the stall is not accepted. Release -> IDLE next edge.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// Execute-stage ALU: single-cycle integer ops plus an iterative M-extension unit
// (shift-add multiply, restoring divide) behind a registered valid/ready result.
module alu_muldiv_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int EN_MULDIV  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] rs1,
  input  logic [DATA_WIDTH-1:0] rs2,
  input  logic [4:0]            alu_control,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  zero,
  output logic                  busy,
  output logic [1:0]            dbg_state
);
  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // a result transfers on a rising edge where out_valid && out_ready. The
  // requester holds in_valid and operands until accepted; rd/zero stay stable
  // while out_valid is high.

  localparam int W       = DATA_WIDTH;
  localparam int SHAMT_W = $clog2(DATA_WIDTH);
  localparam int CNT_W   = SHAMT_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [W-1:0]     MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam bit               MD_EN    = (EN_MULDIV != 0);

  localparam logic [4:0] OP_ADD   = 5'h00;
  localparam logic [4:0] OP_SUB   = 5'h01;
  localparam logic [4:0] OP_SLL   = 5'h02;
  localparam logic [4:0] OP_SLT   = 5'h03;
  localparam logic [4:0] OP_SLTU  = 5'h04;
  localparam logic [4:0] OP_XOR   = 5'h05;
  localparam logic [4:0] OP_SRL   = 5'h06;
  localparam logic [4:0] OP_SRA   = 5'h07;
  localparam logic [4:0] OP_OR    = 5'h08;
  localparam logic [4:0] OP_AND   = 5'h09;
  localparam logic [4:0] OP_MUL   = 5'h0B;
  localparam logic [4:0] OP_MULH  = 5'h0C;
  localparam logic [4:0] OP_MULHU = 5'h0D;
  localparam logic [4:0] OP_DIV   = 5'h0E;
  localparam logic [4:0] OP_DIVU  = 5'h0F;
  localparam logic [4:0] OP_REM   = 5'h10;
  localparam logic [4:0] OP_REMU  = 5'h11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic [W-1:0]     b_q, b_d;
  logic             neg_q, neg_d;
  logic [W-1:0]     rd_q, rd_d;
  logic             zero_q, zero_d;

  // Request-side decode and single-cycle results
  logic [SHAMT_W-1:0] shamt;
  logic [W-1:0]       sc_res;
  logic               is_iter, is_div, is_signed, special;
  logic [W-1:0]       spec_res, now_res, a_op, b_op;

  always_comb begin
    shamt  = rs2[SHAMT_W-1:0];
    sc_res = '0;
    case (alu_control)
      OP_ADD:  sc_res = rs1 + rs2;
      OP_SUB:  sc_res = rs1 - rs2;
      OP_SLL:  sc_res = rs1 << shamt;
      OP_SLT:  sc_res = {{(W-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
      OP_SLTU: sc_res = {{(W-1){1'b0}}, (rs1 < rs2)};
      OP_XOR:  sc_res = rs1 ^ rs2;
      OP_SRL:  sc_res = rs1 >> shamt;
      OP_SRA:  sc_res = $signed(rs1) >>> shamt;
      OP_OR:   sc_res = rs1 | rs2;
      OP_AND:  sc_res = rs1 & rs2;
      default: sc_res = '0;
    endcase
  end

  always_comb begin
    is_iter   = MD_EN && (alu_control >= OP_MUL) && (alu_control <= OP_REMU);
    is_div    = MD_EN && (alu_control >= OP_DIV) && (alu_control <= OP_REMU);
    is_signed = (alu_control == OP_MULH) || (alu_control == OP_DIV) ||
                (alu_control == OP_REM);
    special   = 1'b0;
    spec_res  = '0;
    if (is_div && (rs2 == '0)) begin
      special  = 1'b1;
      spec_res = ((alu_control == OP_DIV) || (alu_control == OP_DIVU)) ? '1 : rs1;
    end else if (is_div && is_signed && (rs1 == MOST_NEG) && (rs2 == '1)) begin
      special  = 1'b1;
      spec_res = (alu_control == OP_DIV) ? MOST_NEG : '0;
    end
    now_res = special ? spec_res : sc_res;
    // Signed ops iterate on magnitudes; MOST_NEG maps to itself, which is its
    // correct unsigned magnitude.
    a_op = (is_signed && rs1[W-1]) ? (~rs1 + 1'b1) : rs1;
    b_op = (is_signed && rs2[W-1]) ? (~rs2 + 1'b1) : rs2;
  end

  // One iteration of each datapath, evaluated from the current registers
  logic [W:0]     mul_sum, div_trial;
  logic [W-1:0]   mul_hi, mul_lo, div_hi, div_lo;
  logic           is_mul_q;
  logic [2*W-1:0] prod, prod_neg;
  logic [W-1:0]   fin_res, quo_fix, rem_fix;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
    mul_hi    = mul_sum[W:1];
    mul_lo    = {mul_sum[0], lo_q[W-1:1]};
    // Partial remainder is always below the divisor, so bit W flags a borrow.
    div_trial = {hi_q, lo_q[W-1]} - {1'b0, b_q};
    div_hi    = div_trial[W] ? {hi_q[W-2:0], lo_q[W-1]} : div_trial[W-1:0];
    div_lo    = {lo_q[W-2:0], ~div_trial[W]};
    is_mul_q  = (op_q >= OP_MUL) && (op_q <= OP_MULHU);
    prod      = {mul_hi, mul_lo};
    prod_neg  = ~prod + 1'b1;
    quo_fix   = neg_q ? (~div_lo + 1'b1) : div_lo;
    rem_fix   = neg_q ? (~div_hi + 1'b1) : div_hi;
    case (op_q)
      OP_MUL:           fin_res = mul_lo;
      OP_MULH:          fin_res = neg_q ? prod_neg[2*W-1:W] : mul_hi;
      OP_MULHU:         fin_res = mul_hi;
      OP_DIV, OP_DIVU:  fin_res = quo_fix;
      OP_REM, OP_REMU:  fin_res = rem_fix;
      default:          fin_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    neg_d   = neg_q;
    rd_d    = rd_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d = alu_control;
          if (is_iter && !special) begin
            state_d = S_CALC;
            cnt_d   = '0;
            hi_d    = '0;
            lo_d    = a_op;
            b_d     = b_op;
            neg_d   = ((alu_control == OP_REM) ? 1'b0 : rs2[W-1]) ^ rs1[W-1];
            neg_d   = is_signed & neg_d;
          end else begin
            state_d = S_DONE;
            rd_d    = now_res;
            zero_d  = (now_res == '0);
          end
        end
      end
      S_CALC: begin
        hi_d  = is_mul_q ? mul_hi : div_hi;
        lo_d  = is_mul_q ? mul_lo : div_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          rd_d    = fin_res;
          zero_d  = (fin_res == '0);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      rd_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      rd_q    <= rd_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign rd        = rd_q;
  assign zero      = zero_q;
  assign dbg_state = state_q;

endmodule
